// File: rtl/tt_um_jleugeri_ttt_scheduler.sv
// Token-transfer sweep sequencer: snapshots start/stop flags on go_in, walks sources in
// order and emits one signed token update per configured target under valid/ready.
module tt_um_jleugeri_ttt_scheduler #(
  parameter int NUM_PROCESSORS = 10,
  parameter int IDX_W          = $clog2(NUM_PROCESSORS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        go_in,
  input  logic [2*NUM_PROCESSORS-1:0] tstartstop_in,
  output logic                        busy_out,
  output logic                        hot_out,
  output logic                        done_out,
  output logic                        cfg_rd_out,
  output logic [IDX_W-1:0]            cfg_idx_out,
  input  logic [IDX_W-1:0]            cfg_first_in,
  input  logic [IDX_W-1:0]            cfg_last_in,
  output logic                        tgt_valid_out,
  input  logic                        tgt_ready_in,
  output logic [IDX_W-1:0]            tgt_idx_out,
  output logic                        tgt_sign_out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    FETCH = 3'd2,
    EMIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [IDX_W:0]   NUM_P    = (IDX_W+1)'(NUM_PROCESSORS);
  localparam logic [IDX_W-1:0] LAST_SRC = IDX_W'(NUM_PROCESSORS - 1);

  state_t                    state_r;
  logic [IDX_W-1:0]          src_r;
  logic [IDX_W-1:0]          tgt_r;
  logic [IDX_W-1:0]          last_r;
  logic                      sign_r;
  logic [NUM_PROCESSORS-1:0] start_r;
  logic [NUM_PROCESSORS-1:0] stop_r;
  logic [NUM_PROCESSORS-1:0] pend_r;
  logic [NUM_PROCESSORS-1:0] start_in_s;
  logic [NUM_PROCESSORS-1:0] stop_in_s;
  logic                      net_s;
  logic                      empty_s;
  logic                      advance_s;

  // Split interleaved start/stop flag pairs into per-processor vectors
  always_comb begin
    start_in_s = '0;
    stop_in_s  = '0;
    for (int i = 0; i < NUM_PROCESSORS; i++) begin
      start_in_s[i] = tstartstop_in[2*i];
      stop_in_s[i]  = tstartstop_in[2*i+1];
    end
  end

  // Net event of the current source and emptiness of the fetched target range
  always_comb begin
    net_s   = start_r[src_r] ^ stop_r[src_r];
    empty_s = (cfg_first_in > cfg_last_in) || ({1'b0, cfg_last_in} >= NUM_P);
  end

  // Conditions under which the sweep moves past the current source
  always_comb begin
    advance_s = 1'b0;
    case (state_r)
      SCAN:    advance_s = !net_s;
      FETCH:   advance_s = empty_s;
      EMIT:    advance_s = tgt_ready_in && (tgt_r == last_r);
      default: advance_s = 1'b0;
    endcase
  end

  // Sweep state machine; the advance step overrides the per-state next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      src_r   <= '0;
      tgt_r   <= '0;
      last_r  <= '0;
      sign_r  <= 1'b0;
      start_r <= '0;
      stop_r  <= '0;
      pend_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (go_in) begin
            start_r <= start_in_s;
            stop_r  <= stop_in_s;
            pend_r  <= start_in_s ^ stop_in_s;
            src_r   <= '0;
            state_r <= SCAN;
          end
        end
        SCAN: begin
          if (net_s) begin
            sign_r  <= start_r[src_r];
            state_r <= FETCH;
          end
        end
        FETCH: begin
          if (!empty_s) begin
            tgt_r   <= cfg_first_in;
            last_r  <= cfg_last_in;
            state_r <= EMIT;
          end
        end
        EMIT: begin
          if (tgt_ready_in && (tgt_r != last_r)) begin
            tgt_r <= tgt_r + IDX_W'(1);
          end
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase

      if (advance_s) begin
        pend_r[src_r] <= 1'b0;
        if (src_r == LAST_SRC) begin
          state_r <= DONE;
        end else begin
          src_r   <= src_r + IDX_W'(1);
          state_r <= SCAN;
        end
      end
    end
  end

  // Outputs decoded purely from registered state, so no input reaches an output
  always_comb begin
    busy_out      = (state_r != IDLE);
    hot_out       = (state_r != IDLE) && (|pend_r);
    done_out      = (state_r == DONE);
    cfg_rd_out    = (state_r == SCAN) && net_s;
    tgt_valid_out = (state_r == EMIT);
    if ((state_r == SCAN) || (state_r == FETCH) || (state_r == EMIT)) begin
      cfg_idx_out = src_r;
    end else begin
      cfg_idx_out = '0;
    end
    if (state_r == EMIT) begin
      tgt_idx_out  = tgt_r;
      tgt_sign_out = sign_r;
    end else begin
      tgt_idx_out  = '0;
      tgt_sign_out = 1'b0;
    end
  end

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_scheduler.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized sweeps scored against a list-based reference of expected updates.
module tb_tt_um_jleugeri_ttt_scheduler;

  localparam int N  = 10;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          go_in;
  logic [2*N-1:0] tstartstop_in;
  logic          busy_out, hot_out, done_out, cfg_rd_out;
  logic [IW-1:0] cfg_idx_out, cfg_first_in, cfg_last_in;
  logic          tgt_valid_out, tgt_ready_in;
  logic [IW-1:0] tgt_idx_out;
  logic          tgt_sign_out;

  tt_um_jleugeri_ttt_scheduler #(.NUM_PROCESSORS(N), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .go_in(go_in), .tstartstop_in(tstartstop_in),
    .busy_out(busy_out), .hot_out(hot_out), .done_out(done_out),
    .cfg_rd_out(cfg_rd_out), .cfg_idx_out(cfg_idx_out),
    .cfg_first_in(cfg_first_in), .cfg_last_in(cfg_last_in),
    .tgt_valid_out(tgt_valid_out), .tgt_ready_in(tgt_ready_in),
    .tgt_idx_out(tgt_idx_out), .tgt_sign_out(tgt_sign_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int sign;
  } upd_t;

  typedef struct {
    logic [2*N-1:0] flags;
    int first;
    int last;
    int exp_done;
    int exp_nupd;
    int exp_idx0;
    int exp_sign0;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   tab_first [N];
  int   tab_last  [N];
  upd_t exp_q[$];
  int   rd_q[$];
  int   trace[$];
  vec_t vecs[8];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_table(input int f, input int l);
    for (int i = 0; i < N; i++) begin
      tab_first[i] = f;
      tab_last[i]  = l;
    end
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_busy"}, busy_out, 0);
    chk({nm, "_hot"}, hot_out, 0);
    chk({nm, "_done"}, done_out, 0);
    chk({nm, "_rd"}, cfg_rd_out, 0);
    chk({nm, "_valid"}, tgt_valid_out, 0);
    chk({nm, "_idx"}, int'(cfg_idx_out) + int'(tgt_idx_out) + int'(tgt_sign_out), 0);
  endtask

  // One full sweep: mode 0 = ready always high, 1 = random ready, 2 = ready low for first 3 valid cycles
  task automatic run_sweep(input logic [2*N-1:0] flags, input int mode,
                           output int done_cyc, output int nupd,
                           output int f_idx, output int f_sign);
    int   base, stalls, vcount, prev_v, prev_idx, prev_sign, any_ev, rd_last;
    logic rdy;
    upd_t u;
    exp_q.delete();
    rd_q.delete();
    trace.delete();
    base = 1 + N;
    any_ev = 0;
    for (int i = 0; i < N; i++) begin
      if (flags[2*i] ^ flags[2*i+1]) begin
        any_ev = 1;
        rd_q.push_back(i);
        base += 1;
        if (tab_first[i] <= tab_last[i] && tab_last[i] < N) begin
          for (int t = tab_first[i]; t <= tab_last[i]; t++) begin
            u.idx = t;
            u.sign = int'(flags[2*i]);
            exp_q.push_back(u);
            base += 1;
          end
        end
      end
    end
    done_cyc = -1; nupd = 0; f_idx = -1; f_sign = -1;
    stalls = 0; vcount = 0; prev_v = 0; prev_idx = 0; prev_sign = 0; rd_last = 0;

    tstartstop_in = flags;
    go_in = 1'b1;
    step();
    go_in = 1'b0;
    tstartstop_in = (2*N)'($urandom);
    chk("hot_start", hot_out, any_ev);
    for (int c = 1; c <= 1500 && done_cyc < 0; c++) begin
      chk("busy", busy_out, 1);
      if (cfg_rd_out) begin
        chk("rd_avail", int'(rd_q.size() > 0), 1);
        if (rd_q.size() > 0) chk("rd_idx", cfg_idx_out, rd_q.pop_front());
      end
      if (prev_v) chk("valid_hold", tgt_valid_out, 1);
      if (tgt_valid_out) begin
        if (prev_v) begin
          chk("hold_idx", tgt_idx_out, prev_idx);
          chk("hold_sign", tgt_sign_out, prev_sign);
        end
        chk("hot_valid", hot_out, 1);
        case (mode)
          0:       rdy = 1'b1;
          2:       rdy = (vcount >= 3);
          default: rdy = ($urandom_range(0, 9) < 7);
        endcase
        vcount++;
        trace.push_back(int'(tgt_idx_out));
        if (rdy) begin
          nupd++;
          if (f_idx < 0) begin
            f_idx = tgt_idx_out;
            f_sign = tgt_sign_out;
          end
          chk("upd_avail", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            u = exp_q.pop_front();
            chk("upd_idx", tgt_idx_out, u.idx);
            chk("upd_sign", tgt_sign_out, u.sign);
          end
          prev_v = 0;
        end else begin
          stalls++;
          prev_v = 1;
          prev_idx = tgt_idx_out;
          prev_sign = tgt_sign_out;
        end
      end else begin
        rdy = 1'($urandom_range(0, 1));
        prev_v = 0;
      end
      if (!any_ev) chk("hot_none", hot_out, 0);
      tgt_ready_in = rdy;
      if (done_out) begin
        done_cyc = c;
        chk("done_cyc", c, base + stalls);
        chk("upd_left", exp_q.size(), 0);
        chk("rd_left", rd_q.size(), 0);
        chk("hot_done", hot_out, 0);
      end
      if (cfg_rd_out) begin
        cfg_first_in = IW'(tab_first[cfg_idx_out]);
        cfg_last_in  = IW'(tab_last[cfg_idx_out]);
      end else if (!rd_last) begin
        cfg_first_in = IW'($urandom);
        cfg_last_in  = IW'($urandom);
      end
      rd_last = cfg_rd_out;
      go_in = busy_out ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
    end
    go_in = 1'b0;
    chk("done_seen", int'(done_cyc >= 0), 1);
    chk("idle_after", busy_out, 0);
    chk("done_pulse", done_out, 0);
  endtask

  initial begin
    int d, n, fi, fs, seen;
    vecs[0] = '{20'h00000, 0, 0, 11, 0, -1, -1};
    vecs[1] = '{20'h00040, 5, 7, 15, 3, 5, 1};
    vecs[2] = '{20'h80030, 0, 0, 13, 1, 0, 0};
    vecs[3] = '{20'h00001, 4, 2, 12, 0, -1, -1};
    vecs[4] = '{20'h00008, 3, 12, 12, 0, -1, -1};
    vecs[5] = '{20'h40000, 9, 9, 13, 1, 9, 1};
    vecs[6] = '{20'h00801, 0, 9, 33, 20, 0, 1};
    vecs[7] = '{20'h55555, 2, 3, 41, 20, 2, 1};

    // Reset held two cycles with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      go_in = 1'($urandom);
      tstartstop_in = (2*N)'($urandom);
      tgt_ready_in = 1'($urandom);
      cfg_first_in = IW'($urandom);
      cfg_last_in = IW'($urandom);
      step();
      chk_quiet("reset");
    end
    rst_n = 1'b1;
    go_in = 1'b0;
    tgt_ready_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_quiet("idle");
    end

    // Directed vector table
    for (int v = 0; v < 8; v++) begin
      set_table(vecs[v].first, vecs[v].last);
      run_sweep(vecs[v].flags, 0, d, n, fi, fs);
      chk($sformatf("vec%0d_done", v), d, vecs[v].exp_done);
      chk($sformatf("vec%0d_nupd", v), n, vecs[v].exp_nupd);
      chk($sformatf("vec%0d_idx0", v), fi, vecs[v].exp_idx0);
      chk($sformatf("vec%0d_sign0", v), fs, vecs[v].exp_sign0);
    end

    // Backpressure: range 1..2, ready low for the first three valid cycles
    set_table(1, 2);
    run_sweep(20'h00100, 2, d, n, fi, fs);
    chk("bp_done", d, 17);
    chk("bp_len", trace.size(), 5);
    if (trace.size() == 5) begin
      for (int i = 0; i < 4; i++) chk("bp_held", trace[i], 1);
      chk("bp_next", trace[4], 2);
    end

    // Reset while emitting: valid drops, no done afterwards
    set_table(0, 9);
    tstartstop_in = 20'h00001;
    go_in = 1'b1;
    step();
    go_in = 1'b0;
    tgt_ready_in = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      if (cfg_rd_out) begin
        cfg_first_in = IW'(tab_first[cfg_idx_out]);
        cfg_last_in = IW'(tab_last[cfg_idx_out]);
      end
      if (tgt_valid_out) seen = 1;
      else step();
    end
    chk("rst_emit_seen", seen, 1);
    step();
    chk("rst_emit_valid", tgt_valid_out, 1);
    rst_n = 1'b0;
    step();
    chk_quiet("rst_emit");
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      chk("post_rst_done", done_out, 0);
      chk("post_rst_valid", tgt_valid_out, 0);
    end

    // Fresh sweep after the aborted one
    set_table(vecs[1].first, vecs[1].last);
    run_sweep(vecs[1].flags, 0, d, n, fi, fs);
    chk("restart_done", d, vecs[1].exp_done);
    chk("restart_nupd", n, vecs[1].exp_nupd);

    // Randomized sweeps against the reference list
    for (int s = 0; s < 25; s++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 9) < 7) begin
          tab_first[i] = $urandom_range(0, N - 1);
          tab_last[i] = $urandom_range(tab_first[i], N - 1);
        end else begin
          tab_first[i] = $urandom_range(0, 15);
          tab_last[i] = $urandom_range(0, 15);
        end
      end
      run_sweep((2*N)'($urandom), 1, d, n, fi, fs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_um_jleugeri_ttt_scheduler.md
# tt_um_jleugeri_ttt_scheduler

Sequencer for the token-transfer network. On each `go_in` it snapshots every processor's start/stop event flags and scans sources 0..NUM_PROCESSORS-1 in order. For each source with a net event, it reads that source's target range from the connection configuration and emits one signed token update per target to the demultiplexer/accumulator, under a valid/ready handshake. It ends the sweep with a one-cycle `done_out`.

## Interface
- `NUM_PROCESSORS`, default 10: number of processors; must be ≥ 2.
- `IDX_W`, default `$clog2(NUM_PROCESSORS)`: processor index width.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `go_in`  in  1  start-sweep pulse; sampled only in IDLE.
- `tstartstop_in`  in  2*NUM_PROCESSORS  event flags: bit 2i = start of processor i, bit 2i+1 = stop of processor i.
- `busy_out`  out  1  high in every state except IDLE.
- `hot_out`  out  1  high while busy and the snapshot holds at least one net event not yet fully emitted.
- `done_out`  out  1  one-cycle pulse at end of sweep.
- `cfg_rd_out`  out  1  connection-table read strobe.
- `cfg_idx_out`  out  IDX_W  source index being read or emitted.
- `cfg_first_in`  in  IDX_W  first target index. Valid exactly one cycle after `cfg_rd_out`.
- `cfg_last_in`  in  IDX_W  last target index, inclusive. Same timing as `cfg_first_in`.
- `tgt_valid_out`  out  1  token update valid.
- `tgt_ready_in`  in  1  downstream accepts the update.
- `tgt_idx_out`  out  IDX_W  target processor index.
- `tgt_sign_out`  out  1  1 = +1 (source started), 0 = −1 (source stopped).

## Operation
- **States:** IDLE, SCAN, FETCH, EMIT, DONE.
- **IDLE:**
  - On `go_in`=1: latch `tstartstop_in` into the snapshot, set src=0, go to SCAN.
  - `go_in` in any other state is ignored.
- **SCAN:** net event of src = start XOR stop.
  - If set: assert `cfg_rd_out`, latch sign = start bit, go to FETCH.
  - Else advance (see below).
  - Start and stop both set means net zero: skip, no emission.
- **FETCH:** capture first/last.
  - If first > last, or last ≥ NUM_PROCESSORS: the range is empty; advance.
  - Else tgt = first, go to EMIT.
- **EMIT:**
  - `tgt_valid_out`=1, `tgt_idx_out`=tgt, `tgt_sign_out`=latched sign.
  - On valid & ready: if tgt == last, advance; else tgt+1.
- **Advance:** if src == NUM_PROCESSORS−1, go to DONE; else src+1, go to SCAN.
- **DONE:** `done_out`=1 for one cycle, go to IDLE.
- **Port mapping:** `cfg_idx_out` = src in SCAN/FETCH/EMIT; 0 in IDLE.
- **Counters:** no wrap. src and tgt never exceed NUM_PROCESSORS−1. A self-target (tgt == src) is emitted normally.
- **Handshake rules:**
  - Once `tgt_valid_out` rises, it and `tgt_idx_out`/`tgt_sign_out` hold stable until accepted.
  - `tgt_valid_out` is never deasserted without acceptance, except by reset.
- **Snapshot:** changes on `tstartstop_in` during a sweep have no effect.
- **Reset mid-operation:** return to IDLE with all outputs at reset values. The aborted sweep produces no `done_out`, and no further updates are emitted.

## Timing
- **Reset values:** every output is 0. State IDLE, src=0, tgt=0, snapshot=0.
- **Output registration:** all outputs registered, or decoded from registered state only. No combinational path from `tgt_ready_in` or `cfg_*_in` to any output.
- **Sweep start:** `go_in` high at edge k puts SCAN(src 0) in cycle k+1.
- **Per-source cost:**
  - Source with no net event: 1 cycle.
  - Source with net event and nonempty range of R targets, ready held high: 1 SCAN + 1 FETCH + R EMIT cycles.
  - Source with net event and empty range: 2 cycles.
- **Sweep length:** `done_out` high in cycle k + 1 + N + Σ(1 + R_i) over event sources, with N = NUM_PROCESSORS. With no events: k+N+1.
- **Consecutive updates:** back-to-back updates within one source, one per cycle, when ready is high.
- **Earliest restart:** `go_in` is re-accepted in the cycle after DONE.

## Test plan
1. **Reset:** hold `rst_n`=0 two cycles with random inputs -> all outputs 0. After release, no activity without `go_in`.
2. **Empty sweep:** N=10, flags all 0, `go_in` at cycle 0 -> `busy_out` high cycles 1–11, `done_out` only at cycle 11, `tgt_valid_out` never high, `hot_out` never high.
3. **Single start:** flags bit 6 set (start p3), table returns 5..7, ready=1, `go_in` at 0:
   - `cfg_rd_out` at cycle 4 with `cfg_idx_out`=3.
   - Updates (5,+), (6,+), (7,+) in cycles 6–8.
   - `done_out` at cycle 15.
4. **Net-zero and stop:** p2 start+stop, p9 stop only, p9 range 0..0:
   - No read or emission for p2.
   - Exactly one update (idx 0, sign 0).
5. **Backpressure:** range 1..2, `tgt_ready_in` low for 3 cycles at first valid -> idx 1 held stable 4 cycles, then idx 2 next cycle. No duplicate and no loss.
6. **Edge cases:**
   - first=4, last=2 -> source skipped in 2 cycles.
   - `go_in` pulsed mid-sweep -> ignored.
   - `rst_n` low during EMIT -> valid drops next cycle, no `done_out`.
   - Subsequent `go_in` -> full correct sweep.
